// File: rtl/cv32e40p_fetch_fifo_writer.sv
// Producer side of the instruction prefetch FIFO: issues OBI fetch requests, pushes in-order
// responses and discards responses belonging to a stream abandoned by a branch.
module cv32e40p_fetch_fifo_writer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_addr_i,
  output logic             busy_o,
  output logic             trans_valid_o,
  input  logic             trans_ready_i,
  output logic [31:0]      trans_addr_o,
  input  logic             resp_valid_i,
  input  logic [31:0]      resp_rdata_i,
  input  logic             resp_err_i,
  input  logic [CNT_W-1:0] fifo_cnt_i,
  output logic             fifo_push_o,
  output logic [32:0]      fifo_wdata_o,
  output logic             fifo_flush_o
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SumW = ((CNT_W > OutW) ? CNT_W : OutW) + 1;

  typedef enum logic [0:0] {StIdle, StBranchWait} state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     tgt_q, tgt_d;
  logic [OutW-1:0] out_cnt_q, out_cnt_d;
  logic [OutW-1:0] flush_cnt_q, flush_cnt_d;
  logic            pend_q, pend_d;
  logic            started_q, started_d;

  logic [31:0]     target;
  logic [SumW-1:0] fill_sum;
  logic            room;
  logic            accept;
  logic            drop;
  logic            flush_dec;
  logic            unused_addr_lsb;

  assign target          = {branch_addr_i[31:2], 2'b00};
  assign unused_addr_lsb = ^branch_addr_i[1:0];

  // A branch flushes the FIFO, so its fill level no longer counts against room.
  assign fill_sum = SumW'(out_cnt_q) + (branch_i ? SumW'(0) : SumW'(fifo_cnt_i));
  assign room     = (out_cnt_q < OutW'(MAX_OUTSTANDING)) && (fill_sum < SumW'(DEPTH));

  always_comb begin
    if (pend_q) begin
      // An unaccepted request is never retracted or altered.
      trans_valid_o = 1'b1;
      trans_addr_o  = addr_q;
    end else begin
      trans_valid_o = req_i & room & (started_q | branch_i);
      trans_addr_o  = branch_i ? target : addr_q;
    end
  end

  assign accept       = trans_valid_o & trans_ready_i;
  assign drop         = resp_valid_i & ((flush_cnt_q != '0) | branch_i);
  assign flush_dec    = resp_valid_i & (flush_cnt_q != '0);
  assign fifo_push_o  = resp_valid_i & ~drop;
  assign fifo_wdata_o = {resp_err_i, resp_rdata_i};
  assign fifo_flush_o = branch_i;
  assign busy_o       = trans_valid_o | (out_cnt_q != '0);

  always_comb begin
    case ({accept, resp_valid_i})
      2'b10:   out_cnt_d = out_cnt_q + OutW'(1);
      2'b01:   out_cnt_d = out_cnt_q - OutW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    started_d   = started_q | branch_i;
    pend_d      = trans_valid_o & ~trans_ready_i;
    flush_cnt_d = flush_cnt_q - OutW'(flush_dec);
    addr_d      = accept ? (trans_addr_o + 32'd4) : trans_addr_o;

    if (branch_i) begin
      // Everything already accepted belongs to the abandoned stream.
      flush_cnt_d = out_cnt_q - OutW'(resp_valid_i);
      if (pend_q) begin
        if (accept) begin
          flush_cnt_d = out_cnt_q - OutW'(resp_valid_i) + OutW'(1);
          addr_d      = target;
          state_d     = StIdle;
        end else begin
          tgt_d   = target;
          state_d = StBranchWait;
        end
      end
    end else if ((state_q == StBranchWait) && accept) begin
      flush_cnt_d = flush_cnt_q - OutW'(flush_dec) + OutW'(1);
      addr_d      = tgt_q;
      state_d     = StIdle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      tgt_q       <= '0;
      out_cnt_q   <= '0;
      flush_cnt_q <= '0;
      pend_q      <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      tgt_q       <= tgt_d;
      out_cnt_q   <= out_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pend_q      <= pend_d;
      started_q   <= started_d;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    !(fifo_push_o && (fifo_cnt_i >= CNT_W'(DEPTH))));

endmodule
